// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order FIFO of pre-decoded instructions feeding the ROB,
// the reservation station and the load/store buffer. The head entry issues
// when the ROB and its target unit both have room; operands are resolved
// from the register file, then the same-cycle CDB, then the ROB.
module dispatch_queue #(
    parameter int DEPTH    = 4,
    parameter int ROB_ID_W = 4,
    parameter int XLEN     = 32,
    parameter int OP_W     = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     in_op,
    input  logic [4:0]          in_rd,
    input  logic [4:0]          in_rs1,
    input  logic [4:0]          in_rs2,
    input  logic [XLEN-1:0]     in_imm,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [XLEN-1:0]     in_next_pc,
    input  logic [1:0]          in_kind,
    output logic [4:0]          rs1_to_reg_file,
    output logic [4:0]          rs2_to_reg_file,
    input  logic [XLEN-1:0]     vj_from_reg_file,
    input  logic [ROB_ID_W-1:0] qj_from_reg_file,
    input  logic [XLEN-1:0]     vk_from_reg_file,
    input  logic [ROB_ID_W-1:0] qk_from_reg_file,
    output logic [ROB_ID_W-1:0] qj_to_ro_buffer,
    output logic [ROB_ID_W-1:0] qk_to_ro_buffer,
    input  logic                valid_of_vj_from_ro_buffer,
    input  logic                valid_of_vk_from_ro_buffer,
    input  logic [XLEN-1:0]     vj_from_ro_buffer,
    input  logic [XLEN-1:0]     vk_from_ro_buffer,
    input  logic [ROB_ID_W-1:0] dest_from_ro_buffer,
    input  logic                rob_full,
    input  logic                rs_full,
    input  logic                lsb_full,
    input  logic                cdb_valid,
    input  logic [ROB_ID_W-1:0] cdb_dest,
    input  logic [XLEN-1:0]     cdb_value,
    output logic                valid_to_ro_buffer,
    output logic [1:0]          signal_to_ro_buffer,
    output logic [4:0]          rd_to_ro_buffer,
    output logic [XLEN-1:0]     pc_to_ro_buffer,
    output logic [XLEN-1:0]     next_pc_to_ro_buffer,
    output logic [4:0]          rd_to_reg_file,
    output logic [ROB_ID_W-1:0] dest_to_reg_file,
    output logic                rs_valid,
    output logic                ls_valid,
    output logic [ROB_ID_W-1:0] dest_out,
    output logic [OP_W-1:0]     op_out,
    output logic [ROB_ID_W-1:0] qj_out,
    output logic [ROB_ID_W-1:0] qk_out,
    output logic [XLEN-1:0]     vj_out,
    output logic [XLEN-1:0]     vk_out,
    output logic [XLEN-1:0]     imm_out,
    output logic [XLEN-1:0]     pc_out
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] next_pc;
        logic [1:0]      kind;
    } entry_t;

    entry_t              mem [DEPTH];
    entry_t              new_entry;
    entry_t              head_entry;
    logic [PTR_W-1:0]    head_reg;
    logic [PTR_W-1:0]    tail_reg;
    logic [CNT_W-1:0]    count_reg;
    logic                enq;
    logic                go;
    logic                unit_full;

    assign new_entry = '{op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                         imm: in_imm, pc: in_pc, next_pc: in_next_pc, kind: in_kind};
    // Head is read asynchronously so its operand indices reach the register
    // file in the same cycle the dispatch decision is made.
    assign head_entry = mem[head_reg];

    // No pass-through when full: a same-cycle dispatch does not free a slot.
    assign in_ready  = rdy && !flush && (count_reg < CNT_W'(DEPTH));
    assign enq       = in_valid && in_ready;
    // Loads and stores (kind 2/3) go to the LSB, everything else to the RS.
    assign unit_full = head_entry.kind[1] ? lsb_full : rs_full;
    assign go        = rdy && !flush && (count_reg != '0) && !rob_full && !unit_full;

    assign rs1_to_reg_file = head_entry.rs1;
    assign rs2_to_reg_file = head_entry.rs2;
    assign qj_to_ro_buffer = qj_from_reg_file;
    assign qk_to_ro_buffer = qk_from_reg_file;

    logic [4:0]          src_idx    [2];
    logic [XLEN-1:0]     src_rf_v   [2];
    logic [ROB_ID_W-1:0] src_rf_q   [2];
    logic                src_rob_ok [2];
    logic [XLEN-1:0]     src_rob_v  [2];

    assign src_idx[0]    = head_entry.rs1;
    assign src_idx[1]    = head_entry.rs2;
    assign src_rf_v[0]   = vj_from_reg_file;
    assign src_rf_v[1]   = vk_from_reg_file;
    assign src_rf_q[0]   = qj_from_reg_file;
    assign src_rf_q[1]   = qk_from_reg_file;
    assign src_rob_ok[0] = valid_of_vj_from_ro_buffer;
    assign src_rob_ok[1] = valid_of_vk_from_ro_buffer;
    assign src_rob_v[0]  = vj_from_ro_buffer;
    assign src_rob_v[1]  = vk_from_ro_buffer;

    // One resolver per source operand (0 = j, 1 = k).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            logic [ROB_ID_W-1:0] res_q;
            logic [XLEN-1:0]     res_v;
            // Priority: x0, ready register, same-cycle CDB, ROB result, else wait on tag.
            always_comb begin
                res_q = '0;
                res_v = '0;
                if (src_idx[gi] != 5'd0) begin
                    if (src_rf_q[gi] == '0) begin
                        res_v = src_rf_v[gi];
                    end else if (cdb_valid && (cdb_dest == src_rf_q[gi])) begin
                        res_v = cdb_value;
                    end else if (src_rob_ok[gi]) begin
                        res_v = src_rob_v[gi];
                    end else begin
                        res_q = src_rf_q[gi];
                    end
                end
            end
        end
    endgenerate

    // Entry storage: no reset needed, validity is tracked by count_reg.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail_reg] <= new_entry;
        end
    end

    // Queue pointers and occupancy; flush empties the queue and drops any enqueue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (rdy) begin
            if (flush) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (enq) tail_reg <= tail_reg + PTR_W'(1);
                if (go)  head_reg <= head_reg + PTR_W'(1);
                case ({enq, go})
                    2'b10:   count_reg <= count_reg + CNT_W'(1);
                    2'b01:   count_reg <= count_reg - CNT_W'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    // Dispatch registers: strobes pulse per dispatch, payload holds between dispatches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_to_ro_buffer   <= 1'b0;
            signal_to_ro_buffer  <= '0;
            rd_to_ro_buffer      <= '0;
            pc_to_ro_buffer      <= '0;
            next_pc_to_ro_buffer <= '0;
            rd_to_reg_file       <= '0;
            dest_to_reg_file     <= '0;
            rs_valid             <= 1'b0;
            ls_valid             <= 1'b0;
            dest_out             <= '0;
            op_out               <= '0;
            qj_out               <= '0;
            qk_out               <= '0;
            vj_out               <= '0;
            vk_out               <= '0;
            imm_out              <= '0;
            pc_out               <= '0;
        end else if (rdy) begin
            if (go) begin
                valid_to_ro_buffer   <= 1'b1;
                signal_to_ro_buffer  <= head_entry.kind;
                rd_to_ro_buffer      <= head_entry.rd;
                pc_to_ro_buffer      <= head_entry.pc;
                next_pc_to_ro_buffer <= head_entry.next_pc;
                // Stores write no register, so they request no rename.
                rd_to_reg_file       <= (head_entry.kind == 2'd3) ? 5'd0 : head_entry.rd;
                dest_to_reg_file     <= dest_from_ro_buffer;
                rs_valid             <= !head_entry.kind[1];
                ls_valid             <= head_entry.kind[1];
                dest_out             <= dest_from_ro_buffer;
                op_out               <= head_entry.op;
                qj_out               <= g_operand[0].res_q;
                vj_out               <= g_operand[0].res_v;
                qk_out               <= g_operand[1].res_q;
                vk_out               <= g_operand[1].res_v;
                imm_out              <= head_entry.imm;
                pc_out               <= head_entry.pc;
            end else begin
                valid_to_ro_buffer <= 1'b0;
                rs_valid           <= 1'b0;
                ls_valid           <= 1'b0;
                rd_to_reg_file     <= '0;
            end
        end
    end
endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue: stimulus pushes hand-computed expected
// dispatches into a scoreboard; a negedge monitor pops and compares each one.
module tb_dispatch_queue;
    localparam int DEPTH = 4;
    localparam int RW    = 4;
    localparam int XLEN  = 32;
    localparam int OP_W  = 6;

    logic clk, rst_n, rdy, flush, in_valid, in_ready;
    logic [OP_W-1:0] in_op;
    logic [4:0] in_rd, in_rs1, in_rs2;
    logic [XLEN-1:0] in_imm, in_pc, in_next_pc;
    logic [1:0] in_kind;
    logic [4:0] rs1_to_reg_file, rs2_to_reg_file;
    logic [XLEN-1:0] vj_from_reg_file, vk_from_reg_file;
    logic [RW-1:0] qj_from_reg_file, qk_from_reg_file;
    logic [RW-1:0] qj_to_ro_buffer, qk_to_ro_buffer;
    logic valid_of_vj_from_ro_buffer, valid_of_vk_from_ro_buffer;
    logic [XLEN-1:0] vj_from_ro_buffer, vk_from_ro_buffer;
    logic [RW-1:0] dest_from_ro_buffer;
    logic rob_full, rs_full, lsb_full, cdb_valid;
    logic [RW-1:0] cdb_dest;
    logic [XLEN-1:0] cdb_value;
    logic valid_to_ro_buffer;
    logic [1:0] signal_to_ro_buffer;
    logic [4:0] rd_to_ro_buffer, rd_to_reg_file;
    logic [XLEN-1:0] pc_to_ro_buffer, next_pc_to_ro_buffer;
    logic [RW-1:0] dest_to_reg_file, dest_out, qj_out, qk_out;
    logic rs_valid, ls_valid;
    logic [OP_W-1:0] op_out;
    logic [XLEN-1:0] vj_out, vk_out, imm_out, pc_out;

    dispatch_queue #(.DEPTH(DEPTH), .ROB_ID_W(RW), .XLEN(XLEN), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
        .in_next_pc(in_next_pc), .in_kind(in_kind),
        .rs1_to_reg_file(rs1_to_reg_file), .rs2_to_reg_file(rs2_to_reg_file),
        .vj_from_reg_file(vj_from_reg_file), .qj_from_reg_file(qj_from_reg_file),
        .vk_from_reg_file(vk_from_reg_file), .qk_from_reg_file(qk_from_reg_file),
        .qj_to_ro_buffer(qj_to_ro_buffer), .qk_to_ro_buffer(qk_to_ro_buffer),
        .valid_of_vj_from_ro_buffer(valid_of_vj_from_ro_buffer),
        .valid_of_vk_from_ro_buffer(valid_of_vk_from_ro_buffer),
        .vj_from_ro_buffer(vj_from_ro_buffer), .vk_from_ro_buffer(vk_from_ro_buffer),
        .dest_from_ro_buffer(dest_from_ro_buffer),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .cdb_valid(cdb_valid), .cdb_dest(cdb_dest), .cdb_value(cdb_value),
        .valid_to_ro_buffer(valid_to_ro_buffer), .signal_to_ro_buffer(signal_to_ro_buffer),
        .rd_to_ro_buffer(rd_to_ro_buffer), .pc_to_ro_buffer(pc_to_ro_buffer),
        .next_pc_to_ro_buffer(next_pc_to_ro_buffer), .rd_to_reg_file(rd_to_reg_file),
        .dest_to_reg_file(dest_to_reg_file), .rs_valid(rs_valid), .ls_valid(ls_valid),
        .dest_out(dest_out), .op_out(op_out), .qj_out(qj_out), .qk_out(qk_out),
        .vj_out(vj_out), .vk_out(vk_out), .imm_out(imm_out), .pc_out(pc_out)
    );

    // Simple register file / ROB models addressed by the DUT's lookup indices.
    logic [RW-1:0]   rfq  [32];
    logic [XLEN-1:0] rfv  [32];
    logic            robok[16];
    logic [XLEN-1:0] robv [16];

    assign qj_from_reg_file = rfq[rs1_to_reg_file];
    assign vj_from_reg_file = rfv[rs1_to_reg_file];
    assign qk_from_reg_file = rfq[rs2_to_reg_file];
    assign vk_from_reg_file = rfv[rs2_to_reg_file];
    assign valid_of_vj_from_ro_buffer = robok[qj_to_ro_buffer];
    assign vj_from_ro_buffer          = robv[qj_to_ro_buffer];
    assign valid_of_vk_from_ro_buffer = robok[qk_to_ro_buffer];
    assign vk_from_ro_buffer          = robv[qk_to_ro_buffer];

    typedef struct {
        logic [1:0]      kind;
        logic [4:0]      rd;
        logic [RW-1:0]   tag;
        logic [OP_W-1:0] op;
        logic [RW-1:0]   qj, qk;
        logic [XLEN-1:0] vj, vk, imm, pc, npc;
        int              enq_cyc;
        bit              chk_lat;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int disp_cnt = 0;
    int d0;
    logic [RW-1:0] tag_cnt = 4'd1;
    logic [RW-1:0] exp_tag = 4'd1;
    logic last_rdy = 1'b0;

    assign dest_from_ro_buffer = tag_cnt;

    function automatic logic [RW-1:0] nxt(input logic [RW-1:0] t);
        return (t == 4'd15) ? 4'd1 : t + 4'd1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        last_rdy <= rdy;
    end

    // Monitor: a strobe after an edge with rdy high is a fresh dispatch.
    always @(negedge clk) begin
        if (rst_n && last_rdy && (rs_valid || ls_valid)) begin
            exp_t e;
            disp_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_dispatch", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                $display("[TB] dispatch cyc=%0d kind=%0d rd=%0d dest=%0d qj=%0d vj=0x%0h qk=%0d vk=0x%0h",
                         cyc, signal_to_ro_buffer, rd_to_ro_buffer, dest_out, qj_out, vj_out, qk_out, vk_out);
                chk("rs_valid", rs_valid, !e.kind[1]);
                chk("ls_valid", ls_valid, e.kind[1]);
                chk("valid_to_rob", valid_to_ro_buffer, 1);
                chk("signal", signal_to_ro_buffer, e.kind);
                chk("rd_to_rob", rd_to_ro_buffer, e.rd);
                chk("pc_to_rob", pc_to_ro_buffer, e.pc);
                chk("next_pc_to_rob", next_pc_to_ro_buffer, e.npc);
                chk("rd_to_reg_file", rd_to_reg_file, (e.kind == 2'd3) ? 5'd0 : e.rd);
                chk("dest_to_reg_file", dest_to_reg_file, e.tag);
                chk("dest_out", dest_out, e.tag);
                chk("op_out", op_out, e.op);
                chk("imm_out", imm_out, e.imm);
                chk("pc_out", pc_out, e.pc);
                chk("qj_out", qj_out, e.qj);
                chk("qk_out", qk_out, e.qk);
                if (e.qj == '0) chk("vj_out", vj_out, e.vj);
                if (e.qk == '0) chk("vk_out", vk_out, e.vk);
                if (e.chk_lat) chk("latency", cyc - e.enq_cyc, 1);
            end
            tag_cnt = nxt(tag_cnt);
        end
    end

    // Offer one instruction at a negedge; expected acceptance and operands are given.
    task automatic enq(input logic [1:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc,
                       input logic [RW-1:0] qj, input logic [XLEN-1:0] vj,
                       input logic [RW-1:0] qk, input logic [XLEN-1:0] vk,
                       input bit exp_acc, input bit lat);
        exp_t e;
        in_valid   = 1'b1;
        in_kind    = kind;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_imm     = imm;
        in_pc      = pc;
        in_next_pc = pc + 32'd4;
        in_op      = {kind, rd[3:0]};
        #1;
        chk("in_ready", in_ready, exp_acc);
        if (exp_acc) begin
            e.kind = kind; e.rd = rd; e.tag = exp_tag; e.op = {kind, rd[3:0]};
            e.qj = qj; e.vj = vj; e.qk = qk; e.vk = vk;
            e.imm = imm; e.pc = pc; e.npc = pc + 32'd4;
            e.enq_cyc = cyc + 1; e.chk_lat = lat;
            exp_tag = nxt(exp_tag);
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            rfq[i] = '0;
            rfv[i] = 32'h1000 + i;
        end
        for (int i = 0; i < 16; i++) begin
            robok[i] = 1'b0;
            robv[i]  = '0;
        end
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_kind = '0;
        in_imm = '0; in_pc = '0; in_next_pc = '0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        cdb_valid = 1'b0; cdb_dest = '0; cdb_value = '0;

        // Reset state
        idle(2);
        chk("rst_rs_valid", rs_valid, 0);
        chk("rst_ls_valid", ls_valid, 0);
        chk("rst_valid_to_rob", valid_to_ro_buffer, 0);
        chk("rst_rd_to_reg_file", rd_to_reg_file, 0);
        chk("rst_dest_out", dest_out, 0);
        chk("rst_pc_out", pc_out, 0);
        rst_n = 1'b1;
        idle(1);
        chk("rst_in_ready", in_ready, 1);

        // Three back-to-back normal instructions, minimum latency
        enq(2'd0, 5'd1, 5'd1, 5'd2, 32'h11, 32'h100, 4'd0, 32'h1001, 4'd0, 32'h1002, 1, 1);
        enq(2'd0, 5'd2, 5'd3, 5'd4, 32'h22, 32'h104, 4'd0, 32'h1003, 4'd0, 32'h1004, 1, 1);
        enq(2'd0, 5'd3, 5'd0, 5'd5, 32'h33, 32'h108, 4'd0, 32'h0,    4'd0, 32'h1005, 1, 1);
        idle(3);

        // Fill to DEPTH while RS is full; fifth offer refused
        rs_full = 1'b1;
        for (int i = 0; i < 5; i++)
            enq(2'd0, 5'(10 + i), 5'd1, 5'd2, 32'(i), 32'h200 + 32'(4 * i),
                4'd0, 32'h1001, 4'd0, 32'h1002, (i < 4), 0);
        chk("full_in_ready", in_ready, 0);
        d0 = disp_cnt;
        idle(2);
        chk("rs_full_no_dispatch", disp_cnt - d0, 0);
        rs_full = 1'b0;
        idle(6);
        chk("drain_count", disp_cnt - d0, 4);
        chk("drain_in_ready", in_ready, 1);

        // Blocked load head holds the normal instruction behind it
        lsb_full = 1'b1;
        enq(2'd2, 5'd4, 5'd1, 5'd0, 32'h44, 32'h300, 4'd0, 32'h1001, 4'd0, 32'h0, 1, 0);
        enq(2'd0, 5'd5, 5'd2, 5'd3, 32'h55, 32'h304, 4'd0, 32'h1002, 4'd0, 32'h1003, 1, 0);
        d0 = disp_cnt;
        idle(3);
        chk("inorder_blocked", disp_cnt - d0, 0);
        lsb_full = 1'b0;
        idle(4);
        chk("inorder_released", disp_cnt - d0, 2);

        // Operand resolution: CDB, CDB over ROB, ROB, pending tag
        rfq[6] = 4'd5;
        cdb_valid = 1'b1; cdb_dest = 4'd5; cdb_value = 32'hDEAD;
        enq(2'd0, 5'd8, 5'd6, 5'd7, 32'h66, 32'h400, 4'd0, 32'hDEAD, 4'd0, 32'h1007, 1, 1);
        idle(3);
        robok[5] = 1'b1; robv[5] = 32'hBEEF;
        enq(2'd0, 5'd8, 5'd6, 5'd7, 32'h67, 32'h404, 4'd0, 32'hDEAD, 4'd0, 32'h1007, 1, 1);
        idle(3);
        cdb_valid = 1'b0;
        enq(2'd0, 5'd8, 5'd6, 5'd7, 32'h68, 32'h408, 4'd0, 32'hBEEF, 4'd0, 32'h1007, 1, 1);
        idle(3);
        robok[5] = 1'b0;
        enq(2'd0, 5'd8, 5'd6, 5'd7, 32'h69, 32'h40C, 4'd5, 32'h0, 4'd0, 32'h1007, 1, 1);
        idle(3);
        rfq[6] = 4'd0;

        // Store: no rename; x0 operands ignore reg-file inputs
        rfq[0] = 4'd3; rfv[0] = 32'h55;
        enq(2'd3, 5'd7, 5'd0, 5'd0, 32'h77, 32'h500, 4'd0, 32'h0, 4'd0, 32'h0, 1, 1);
        idle(3);
        rfq[0] = 4'd0;

        // rdy low holds strobes and blocks enqueue
        enq(2'd0, 5'd9, 5'd1, 5'd2, 32'h88, 32'h600, 4'd0, 32'h1001, 4'd0, 32'h1002, 1, 1);
        idle(1);
        rdy = 1'b0;
        idle(1);
        chk("rdy_low_hold_rs_valid", rs_valid, 1);
        chk("rdy_low_in_ready", in_ready, 0);
        rdy = 1'b1;
        idle(1);
        chk("rdy_high_strobe_clear", rs_valid, 0);

        // Flush with 3 queued and an offered entry
        rs_full = 1'b1;
        for (int i = 0; i < 3; i++)
            enq(2'd0, 5'(20 + i), 5'd1, 5'd2, 32'h0, 32'h700 + 32'(4 * i),
                4'd0, 32'h1001, 4'd0, 32'h1002, 1, 0);
        flush = 1'b1; rs_full = 1'b0;
        in_valid = 1'b1; in_kind = 2'd0; in_rd = 5'd12; in_rs1 = 5'd1; in_rs2 = 5'd2;
        in_pc = 32'h7F0; in_next_pc = 32'h7F4; in_imm = 32'h0; in_op = 6'h0C;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_rs_valid", rs_valid, 0);
        chk("flush_valid_to_rob", valid_to_ro_buffer, 0);
        chk("flush_rd_to_reg_file", rd_to_reg_file, 0);
        sb.delete();
        exp_tag = tag_cnt;
        d0 = disp_cnt;
        idle(3);
        chk("flush_no_dispatch", disp_cnt - d0, 0);
        chk("flush_in_ready", in_ready, 1);
        enq(2'd1, 5'd13, 5'd1, 5'd2, 32'h99, 32'h800, 4'd0, 32'h1001, 4'd0, 32'h1002, 1, 1);
        idle(3);

        // Asynchronous reset while dispatching
        enq(2'd0, 5'd14, 5'd1, 5'd2, 32'hA0, 32'h900, 4'd0, 32'h1001, 4'd0, 32'h1002, 1, 1);
        enq(2'd0, 5'd15, 5'd3, 5'd4, 32'hA1, 32'h904, 4'd0, 32'h1003, 4'd0, 32'h1004, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rs_valid", rs_valid, 0);
        chk("async_rst_valid_to_rob", valid_to_ro_buffer, 0);
        chk("async_rst_dest_out", dest_out, 0);
        chk("async_rst_pc_to_rob", pc_to_ro_buffer, 0);
        chk("async_rst_dest_to_reg_file", dest_to_reg_file, 0);
        sb.delete();
        exp_tag = tag_cnt;
        d0 = disp_cnt;
        idle(1);
        rst_n = 1'b1;
        idle(3);
        chk("post_rst_no_dispatch", disp_cnt - d0, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
